// File: rtl/egr_tb_tagring_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// egr_tb_tagring_gen : N_CH credit-flow tag generators with LFSR lengths.
// Define EGR_TB_TAGGEN_SCOREBOARD_EN to check returned tags.  Rev 1.0
// ---------------------------------------------------------------------------
module egr_tb_tagring_gen #(
    parameter int N_CH    = 32,
    parameter int SEQ_W   = 16,
    parameter int LEN_W   = 14,
    parameter int CNT_W   = 16,
    parameter int GAP_W   = 8,
    parameter int CREDITS = 8,
    parameter int MIN_LEN = 64,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int TAG_W  = CH_W + SEQ_W + LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start_i,
    input  logic [N_CH-1:0]       cfg_ch_en_i,
    input  logic [CNT_W-1:0]      cfg_num_tags_i,
    input  logic [GAP_W-1:0]      cfg_gap_i,
    input  logic [15:0]           cfg_seed_i,
    input  logic [N_CH-1:0]       credit_ret_i,
    input  logic [N_CH-1:0]       ret_valid_i,
    input  logic [N_CH*TAG_W-1:0] ret_data_i,
    output logic [N_CH-1:0]       tag_valid_o,
    output logic [N_CH*TAG_W-1:0] tag_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [N_CH-1:0]       err_credit_o,
    output logic [N_CH-1:0]       err_seq_o
);
    localparam int               CR_W        = $clog2(CREDITS + 1);
    localparam logic [CR_W-1:0]  C_CREDITS   = CR_W'(CREDITS);
    localparam logic [LEN_W-1:0] C_MIN_LEN   = LEN_W'(MIN_LEN);
    localparam logic [15:0]      C_LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [N_CH-1:0]  w_active;
    logic [N_CH-1:0]  w_done_ch;
    logic             w_start;
    logic [CNT_W-1:0] num_q;
    logic [GAP_W-1:0] gap_cfg_q;
    logic             done_q;

    assign busy_o  = |w_active;
    assign w_start = cfg_start_i & ~busy_o;
    assign done_o  = done_q;

    // done is forced low on an accepted start so a stale completion never leaks into the new run
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q     <= '0;
            gap_cfg_q <= '0;
            done_q    <= 1'b0;
        end else begin
            if (w_start) begin
                num_q     <= cfg_num_tags_i;
                gap_cfg_q <= cfg_gap_i;
            end
            done_q <= w_start ? 1'b0 : &w_done_ch;
        end
    end

`ifndef EGR_TB_TAGGEN_SCOREBOARD_EN
    logic unused_ret;
    assign unused_ret = ^{ret_valid_i, ret_data_i};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            localparam logic [CH_W-1:0] C_ID       = CH_W'(gi);
            localparam logic [15:0]     C_SEED_MIX = 16'(gi);

            state_t           state_q, state_d;
            logic [CR_W-1:0]  credit_q, credit_d;
            logic [SEQ_W-1:0] seq_q;
            logic [CNT_W-1:0] sent_q;
            logic [GAP_W-1:0] gap_q;
            logic [15:0]      lfsr_q;
            logic [TAG_W-1:0] tag_q;
            logic             valid_q;
            logic             err_credit_q;
            logic             w_issue, w_ret, w_overflow, w_drained;
            logic [15:0]      w_seed_mix, w_seed, w_lfsr_nxt;
            logic [LEN_W-1:0] w_len;

            assign w_seed_mix = cfg_seed_i ^ C_SEED_MIX;
            assign w_seed     = (w_seed_mix == 16'h0) ? 16'h1 : w_seed_mix;
            assign w_lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? C_LFSR_TAPS : 16'h0);
            assign w_len      = (lfsr_q[LEN_W-1:0] < C_MIN_LEN) ? C_MIN_LEN : lfsr_q[LEN_W-1:0];

            assign w_issue    = (state_q == ST_RUN) && (credit_q != '0) &&
                                (gap_q == '0) && (sent_q < num_q);
            assign w_ret      = credit_ret_i[gi];
            assign w_overflow = w_ret && !w_issue && (credit_q == C_CREDITS);

`ifdef EGR_TB_TAGGEN_SCOREBOARD_EN
            logic [SEQ_W-1:0] exp_seq_q;
            logic [CNT_W-1:0] ret_cnt_q;
            logic             err_seq_q;
            logic [TAG_W-1:0] w_ret_tag;

            assign w_ret_tag = ret_data_i[gi*TAG_W +: TAG_W];
            assign w_drained = (credit_q == C_CREDITS) && (ret_cnt_q == sent_q);

            always_ff @(posedge clk) begin
                if (rst || w_start) begin
                    exp_seq_q <= '0;
                    ret_cnt_q <= '0;
                    err_seq_q <= 1'b0;
                end else if (ret_valid_i[gi]) begin
                    if ((w_ret_tag[TAG_W-1 -: CH_W] != C_ID) ||
                        (w_ret_tag[LEN_W +: SEQ_W] != exp_seq_q)) begin
                        err_seq_q <= 1'b1;
                    end
                    exp_seq_q <= exp_seq_q + SEQ_W'(1);
                    ret_cnt_q <= ret_cnt_q + CNT_W'(1);
                end
            end
            assign err_seq_o[gi] = err_seq_q;
`else
            assign w_drained     = (credit_q == C_CREDITS);
            assign err_seq_o[gi] = 1'b0;
`endif

            always_comb begin
                state_d = state_q;
                case (state_q)
                    ST_IDLE, ST_DONE: if (w_start) state_d = cfg_ch_en_i[gi] ? ST_RUN : ST_DONE;
                    ST_RUN:           if (sent_q == num_q) state_d = ST_DRAIN;
                    ST_DRAIN:         if (w_drained) state_d = ST_DONE;
                    default:          state_d = ST_IDLE;
                endcase
            end

            // An issue and a return in the same cycle cancel; an overflowing return is dropped
            always_comb begin
                credit_d = credit_q;
                if (w_issue && !w_ret) begin
                    credit_d = credit_q - CR_W'(1);
                end else if (w_ret && !w_issue && !w_overflow) begin
                    credit_d = credit_q + CR_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q      <= ST_IDLE;
                    credit_q     <= '0;
                    seq_q        <= '0;
                    sent_q       <= '0;
                    gap_q        <= '0;
                    lfsr_q       <= 16'h1;
                    tag_q        <= '0;
                    valid_q      <= 1'b0;
                    err_credit_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    valid_q <= w_issue;
                    if (w_start) begin
                        credit_q     <= C_CREDITS;
                        seq_q        <= '0;
                        sent_q       <= '0;
                        gap_q        <= '0;
                        lfsr_q       <= w_seed;
                        err_credit_q <= 1'b0;
                    end else begin
                        credit_q <= credit_d;
                        if (w_overflow) err_credit_q <= 1'b1;
                        if (w_issue) begin
                            tag_q  <= {C_ID, seq_q, w_len};
                            seq_q  <= seq_q + SEQ_W'(1);
                            sent_q <= sent_q + CNT_W'(1);
                            lfsr_q <= w_lfsr_nxt;
                            gap_q  <= gap_cfg_q;
                        end else if (gap_q != '0) begin
                            gap_q <= gap_q - GAP_W'(1);
                        end
                    end
                end
            end

            assign tag_valid_o[gi]                = valid_q;
            assign tag_data_o[gi*TAG_W +: TAG_W]  = tag_q;
            assign err_credit_o[gi]               = err_credit_q;
            assign w_active[gi]                   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
            assign w_done_ch[gi]                  = (state_q == ST_DONE);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_egr_tb_tagring_gen.sv
`default_nettype none
// Directed bench for egr_tb_tagring_gen; SEQ_W is narrowed to 8 so the
// sequence-wrap scenario completes in a few hundred cycles.
module tb_egr_tb_tagring_gen;
    localparam int N_CH    = 32;
    localparam int SEQ_W   = 8;
    localparam int LEN_W   = 14;
    localparam int CNT_W   = 16;
    localparam int GAP_W   = 8;
    localparam int CREDITS = 8;
    localparam int MIN_LEN = 64;
    localparam int CH_W    = 5;
    localparam int TAG_W   = CH_W + SEQ_W + LEN_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_start;
    logic [N_CH-1:0]       cfg_ch_en;
    logic [CNT_W-1:0]      cfg_num_tags;
    logic [GAP_W-1:0]      cfg_gap;
    logic [15:0]           cfg_seed;
    logic [N_CH-1:0]       credit_ret;
    logic [N_CH-1:0]       ret_valid;
    logic [N_CH*TAG_W-1:0] ret_data;
    logic [N_CH-1:0]       tag_valid;
    logic [N_CH*TAG_W-1:0] tag_data;
    logic                  busy;
    logic                  done;
    logic [N_CH-1:0]       err_credit;
    logic [N_CH-1:0]       err_seq;

    int n_run  = 0;
    int n_fail = 0;

    egr_tb_tagring_gen #(
        .N_CH(N_CH), .SEQ_W(SEQ_W), .LEN_W(LEN_W), .CNT_W(CNT_W),
        .GAP_W(GAP_W), .CREDITS(CREDITS), .MIN_LEN(MIN_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_start_i(cfg_start), .cfg_ch_en_i(cfg_ch_en), .cfg_num_tags_i(cfg_num_tags),
        .cfg_gap_i(cfg_gap), .cfg_seed_i(cfg_seed), .credit_ret_i(credit_ret),
        .ret_valid_i(ret_valid), .ret_data_i(ret_data),
        .tag_valid_o(tag_valid), .tag_data_o(tag_data), .busy_o(busy), .done_o(done),
        .err_credit_o(err_credit), .err_seq_o(err_seq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TAG_W-1:0] tag_of(input int ch);
        return tag_data[ch*TAG_W +: TAG_W];
    endfunction

    task automatic do_start(input logic [N_CH-1:0] en, input int num, input int gap,
                            input logic [15:0] seed);
        cfg_ch_en    = en;
        cfg_num_tags = CNT_W'(num);
        cfg_gap      = GAP_W'(gap);
        cfg_seed     = seed;
        cfg_start    = 1'b1;
        tick();
        cfg_start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        n_run++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_run++;
        if (tag_valid !== '0 || tag_data !== '0) begin
            n_fail++;
            $display("FAIL reset_tags: valid=%h data_nonzero=%b, required 0", tag_valid, |tag_data);
        end
        n_run++;
        if ({busy, done} !== 2'b00 || err_credit !== '0 || err_seq !== '0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b errc=%h errs=%h, required 0",
                     busy, done, err_credit, err_seq);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [LEN_W-1:0] exp_len [4] = '{14'd64, 14'd13312, 14'd6656, 14'd11520};
        logic [TAG_W-1:0] exp_tag;
        do_start(32'h1, 4, 0, 16'h1);
        n_run++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b, required 1", busy);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_tag = {5'd0, SEQ_W'(k), exp_len[k]};
            n_run++;
            if (tag_valid !== 32'h1 || tag_of(0) !== exp_tag) begin
                n_fail++;
                $display("FAIL basic_tag%0d: valid=%h tag=%h, required valid=00000001 tag=%h",
                         k, tag_valid, tag_of(0), exp_tag);
            end
        end
        tick();
        n_run++;
        if (tag_valid !== '0 || tag_of(0) !== exp_tag) begin
            n_fail++;
            $display("FAIL basic_hold: valid=%h tag=%h, required valid=0 tag=%h",
                     tag_valid, tag_of(0), exp_tag);
        end
        credit_ret = 32'h1;
        repeat (4) tick();
        credit_ret = '0;
        wait_done(10, "basic");
        n_run++;
        if (busy !== 1'b0 || err_credit !== '0 || err_seq !== '0) begin
            n_fail++;
            $display("FAIL basic_end: busy=%b errc=%h errs=%h, required 0", busy, err_credit, err_seq);
        end
    endtask

    task automatic test_credit_stall();
        int cnt = 0;
        do_start(32'h1, 20, 0, 16'h1);
        repeat (20) begin
            tick();
            if (tag_valid[0]) cnt++;
        end
        n_run++;
        if (cnt != 8 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_count: tags=%0d busy=%b done=%b, required 8/1/0", cnt, busy, done);
        end
        cnt = 0;
        credit_ret = 32'h1;
        repeat (20) begin
            tick();
            if (tag_valid[0]) cnt++;
        end
        credit_ret = '0;
        repeat (3) begin
            tick();
            if (tag_valid[0]) cnt++;
        end
        n_run++;
        if (cnt != 12 || tag_of(0)[LEN_W +: SEQ_W] !== SEQ_W'(19)) begin
            n_fail++;
            $display("FAIL stall_resume: tags=%0d last_seq=%0d, required 12/19",
                     cnt, tag_of(0)[LEN_W +: SEQ_W]);
        end
        wait_done(10, "stall");
        n_run++;
        if (err_credit !== '0) begin
            n_fail++;
            $display("FAIL stall_errc: errc=%h, required 0", err_credit);
        end
    endtask

    task automatic test_gap();
        int pos [3] = '{0, 0, 0};
        int np = 0;
        do_start(32'h1, 3, 3, 16'h1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (tag_valid[0]) begin
                if (np < 3) pos[np] = c;
                np++;
            end
        end
        n_run++;
        if (np != 3 || pos[0] != 1 || pos[1] != 5 || pos[2] != 9) begin
            n_fail++;
            $display("FAIL gap_spacing: n=%0d at %0d,%0d,%0d, required 3 at 1,5,9",
                     np, pos[0], pos[1], pos[2]);
        end
        credit_ret = 32'h1;
        repeat (3) tick();
        credit_ret = '0;
        wait_done(10, "gap");
    endtask

    task automatic test_all_zero();
        int  cyc = 0;
        logic seen = 1'b0;
        do_start('1, 0, 0, 16'h1);
        while (done !== 1'b1 && cyc < 6) begin
            tick();
            cyc++;
            if (tag_valid !== '0) seen = 1'b1;
        end
        n_run++;
        if (done !== 1'b1 || cyc > 3 || seen) begin
            n_fail++;
            $display("FAIL zero_done: done=%b cycles=%0d tag_seen=%b, required 1/<=3/0",
                     done, cyc, seen);
        end
    endtask

    task automatic test_seq_wrap();
        int cnt = 0;
        int cyc = 0;
        do_start(32'h1, 300, 0, 16'h5);
        while (cnt < 300 && cyc < 2000) begin
            tick();
            cyc++;
            credit_ret = '0;
            if (tag_valid[0]) begin
                n_run++;
                if (tag_of(0)[LEN_W +: SEQ_W] !== SEQ_W'(cnt) || tag_of(0)[TAG_W-1 -: CH_W] !== 5'd0) begin
                    n_fail++;
                    $display("FAIL wrap_seq%0d: seq=%0d ch=%0d, required %0d/0", cnt,
                             tag_of(0)[LEN_W +: SEQ_W], tag_of(0)[TAG_W-1 -: CH_W], cnt % 256);
                end
                cnt++;
                credit_ret = 32'h1;
            end
        end
        tick();
        credit_ret = '0;
        n_run++;
        if (cnt != 300) begin
            n_fail++;
            $display("FAIL wrap_count: tags=%0d, required 300", cnt);
        end
        wait_done(10, "wrap");
        n_run++;
        if (err_credit !== '0 || err_seq !== '0) begin
            n_fail++;
            $display("FAIL wrap_err: errc=%h errs=%h, required 0", err_credit, err_seq);
        end
    endtask

    task automatic test_err_reset();
        credit_ret = 32'h20;
        tick();
        credit_ret = '0;
        n_run++;
        if (err_credit !== 32'h20) begin
            n_fail++;
            $display("FAIL errc_set: errc=%h, required 00000020", err_credit);
        end
        do_start(32'h3, 10, 0, 16'h1);
        n_run++;
        if (err_credit !== '0) begin
            n_fail++;
            $display("FAIL errc_clear: errc=%h, required 0", err_credit);
        end
        repeat (3) tick();
        n_run++;
        if (busy !== 1'b1 || tag_valid !== 32'h3) begin
            n_fail++;
            $display("FAIL midrun: busy=%b valid=%h, required 1/00000003", busy, tag_valid);
        end
        rst = 1'b1;
        tick();
        n_run++;
        if (tag_valid !== '0 || tag_data !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            err_credit !== '0 || err_seq !== '0) begin
            n_fail++;
            $display("FAIL midrun_rst: valid=%h data_nz=%b busy=%b done=%b errc=%h, required 0",
                     tag_valid, |tag_data, busy, done, err_credit);
        end
        rst = 1'b0;
        tick();
    endtask

`ifdef EGR_TB_TAGGEN_SCOREBOARD_EN
    task automatic test_scoreboard();
        logic [TAG_W-1:0] cap [4];
        int order [4] = '{0, 2, 1, 3};
        int n = 0;
        do_start(32'h8, 4, 0, 16'h1);
        repeat (10) begin
            tick();
            if (tag_valid[3]) begin
                if (n < 4) cap[n] = tag_of(3);
                n++;
            end
        end
        n_run++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL sb_count: tags=%0d, required 4", n);
        end
        for (int j = 0; j < 4; j++) begin
            ret_valid                   = 32'h8;
            ret_data[3*TAG_W +: TAG_W]  = cap[order[j]];
            credit_ret                  = 32'h8;
            tick();
        end
        ret_valid  = '0;
        credit_ret = '0;
        tick();
        n_run++;
        if (err_seq !== 32'h8) begin
            n_fail++;
            $display("FAIL sb_err_seq: errs=%h, required 00000008", err_seq);
        end
        wait_done(10, "sb");
    endtask
`endif

    initial begin
        rst          = 1'b1;
        cfg_start    = 1'b0;
        cfg_ch_en    = '0;
        cfg_num_tags = '0;
        cfg_gap      = '0;
        cfg_seed     = '0;
        credit_ret   = '0;
        ret_valid    = '0;
        ret_data     = '0;
        test_reset();
        test_basic();
        test_credit_stall();
        test_gap();
        test_all_zero();
        test_seq_wrap();
        test_err_reset();
`ifdef EGR_TB_TAGGEN_SCOREBOARD_EN
        test_scoreboard();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
